// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// mult/multu/div/divu occupy the unit for a fixed cycle count; mthi/mtlo finish in one edge.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state;
  op_e              op_q;
  logic [31:0]      a_q, b_q;
  logic [CNT_W-1:0] count;

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, div_b;
  logic [31:0] q_mag, r_mag, quot_s, rem_s, quot_u, rem_u;
  logic        div_zero;

  // Results are formed combinationally from the latched operands and committed on the last RUN edge.
  // NOTE: every signal below is assigned on every path through the block, so no latch is inferred.
  always_comb begin
    prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u   = {32'd0, a_q} * {32'd0, b_q};
    div_zero = (b_q == 32'd0);
    div_b    = div_zero ? 32'd1 : b_q;
    abs_a    = a_q[31] ? -a_q : a_q;
    abs_b    = div_zero ? 32'd1 : (b_q[31] ? -b_q : b_q);
    q_mag    = abs_a / abs_b;
    r_mag    = abs_a % abs_b;
    // Sign-magnitude division keeps 0x80000000 / -1 well defined: the magnitude wraps back to 0x80000000.
    quot_s   = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
    rem_s    = a_q[31] ? -r_mag : r_mag;
    quot_u   = a_q / div_b;
    rem_u    = a_q % div_b;
  end

  assign busy = (state == RUN);

  // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= OP_NONE;
      a_q   <= '0;
      b_q   <= '0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (mdu_op)
              OP_MULT, OP_MULTU: begin
                op_q  <= op_e'(mdu_op);
                a_q   <= in_a;
                b_q   <= in_b;
                count <= CNT_W'(MULT_CYCLES);
                state <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                op_q  <= op_e'(mdu_op);
                a_q   <= in_a;
                b_q   <= in_b;
                count <= CNT_W'(DIV_CYCLES);
                state <= RUN;
              end
              OP_MTHI: hi <= in_a;
              OP_MTLO: lo <= in_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= IDLE;
            case (op_q)
              OP_MULT:  {hi, lo} <= prod_s;
              OP_MULTU: {hi, lo} <= prod_u;
              OP_DIV: begin
                if (!div_zero) begin
                  lo <= quot_s;
                  hi <= rem_s;
                end
              end
              OP_DIVU: begin
                if (!div_zero) begin
                  lo <= quot_u;
                  hi <= rem_u;
                end
              end
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: expected HI/LO and busy length are queued at issue
// and popped when the unit drops busy.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] in_a, in_b;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .in_a   (in_a),
    .in_b   (in_b),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  // Reference model built on 64-bit integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t            e;
    longint          sp;
    longint unsigned up;
    e.hi = 32'd0;
    e.lo = 32'd0;
    e.cycles = 0;
    case (op)
      3'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        e.hi = sp[63:32]; e.lo = sp[31:0]; e.cycles = MC;
      end
      3'd2: begin
        up = {32'd0, a} * {32'd0, b};
        e.hi = up[63:32]; e.lo = up[31:0]; e.cycles = MC;
      end
      3'd3: begin
        sp = longint'($signed(a)) / longint'($signed(b));
        e.lo = sp[31:0];
        sp = longint'($signed(a)) % longint'($signed(b));
        e.hi = sp[31:0]; e.cycles = DC;
      end
      3'd4: begin
        e.lo = a / b; e.hi = a % b; e.cycles = DC;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int ecyc, input int inject_at);
    logic [31:0] h0, l0;
    int          cnt;
    bit          held;
    exp_t        e;
    sb.push_back('{ehi, elo, ecyc});
    @(negedge clk);
    h0 = hi; l0 = lo;
    start = 1'b1; mdu_op = op; in_a = a; in_b = b;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    cnt = 0; held = 1'b1;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
      if (cnt == inject_at) begin
        start = 1'b1; mdu_op = 3'd6; in_a = 32'h0000_AAAA;
      end
      @(negedge clk);
      start = 1'b0; mdu_op = 3'd0;
    end
    e = sb.pop_front();
    checks++;
    if (cnt !== e.cycles) begin
      errors++; $display("FAIL %s busy_cycles got %0d exp %0d", name, cnt, e.cycles);
    end
    checks++;
    if (hi !== e.hi) begin
      errors++; $display("FAIL %s hi got %h exp %h", name, hi, e.hi);
    end
    checks++;
    if (lo !== e.lo) begin
      errors++; $display("FAIL %s lo got %h exp %h", name, lo, e.lo);
    end
    checks++;
    if (!held) begin
      errors++; $display("FAIL %s hilo_hold changed during busy, exp held %h/%h", name, h0, l0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mdu_op = 3'd0; in_a = '0; in_b = '0;
    #12;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++;
    if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC, 0);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MC, 0);
  endtask

  task automatic test_div();
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC, 0);
    run_op("divu", 3'd4, 32'd7, 32'd2, 32'd1, 32'd3, DC, 0);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DC, 0);
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd5; in_a = 32'h0000_1234;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", busy); end
    mdu_op = 3'd6; in_a = 32'h0000_5678;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got %b exp 0", busy); end
    checks++;
    if (hi !== 32'h0000_1234) begin errors++; $display("FAIL mthi_val got %h exp 00001234", hi); end
    checks++;
    if (lo !== 32'h0000_5678) begin errors++; $display("FAIL mtlo_val got %h exp 00005678", lo); end
    // An undefined op with start must leave everything untouched.
    start = 1'b1; mdu_op = 3'd7; in_a = 32'hDEAD_BEEF; in_b = 32'd1;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0000_1234 || lo !== 32'h0000_5678) begin
      errors++; $display("FAIL undef_op got busy=%b hi=%h lo=%h exp 0/00001234/00005678", busy, hi, lo);
    end
    run_op("div_by_zero", 3'd3, 32'd99, 32'd0, 32'h0000_1234, 32'h0000_5678, DC, 0);
    run_op("divu_by_zero", 3'd4, 32'd99, 32'd0, 32'h0000_1234, 32'h0000_5678, DC, 0);
  endtask

  task automatic test_start_in_run();
    run_op("div_inject", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DC, 3);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd1; in_a = 32'd5; in_b = 32'd6;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL abort_reset got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op("mult_after_abort", 3'd1, 32'd5, 32'd6, 32'd0, 32'd30, MC, 0);
  endtask

  task automatic test_back_to_back_random();
    exp_t        e;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      b  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 9));
      if (op >= 3'd3 && b == 32'd0) b = 32'd1;
      if (op == 3'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      e = model(op, a, b);
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, e.hi, e.lo, e.cycles, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_start_in_run();
    test_reset_abort();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
